// File: rtl/snoop_txn_sequencer.sv
// Snoop bus sequencer: round-robin grant, snoop ack collection,
// optional memory access and completion pulse, one transaction at a time.
module snoop_txn_sequencer #(
    parameter int NUM_CPUS = 4,
    parameter int XLEN     = 32,
    parameter int IDW      = $clog2(NUM_CPUS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CPUS-1:0]            req,
    input  logic [NUM_CPUS-1:0][1:0]       req_tx,
    input  logic [NUM_CPUS-1:0][XLEN-1:0]  req_addr,
    output logic [NUM_CPUS-1:0]            gnt,
    output logic                           bus_valid,
    output logic [IDW-1:0]                 bus_src,
    output logic [1:0]                     bus_tx,
    output logic [XLEN-1:0]                bus_addr,
    input  logic [NUM_CPUS-1:0]            snoop_ack,
    input  logic [NUM_CPUS-1:0]            snoop_hit,
    input  logic [NUM_CPUS-1:0]            snoop_supply,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [XLEN-1:0]                mem_addr,
    input  logic                           mem_resp,
    output logic [NUM_CPUS-1:0]            done,
    output logic                           shared,
    output logic                           busy
);

    localparam logic [1:0] TX_BUSRD  = 2'd0;
    localparam logic [1:0] TX_BUSRDX = 2'd1;
    localparam logic [1:0] TX_FLUSH  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SNOOP,
        S_MEM,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_q, rr_d;
    logic [IDW-1:0]        src_q, src_d;
    logic [1:0]            tx_q, tx_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [NUM_CPUS-1:0]   ack_q, ack_d;
    logic [NUM_CPUS-1:0]   hit_q, hit_d;
    logic [NUM_CPUS-1:0]   sup_q, sup_d;
    logic [NUM_CPUS-1:0]   gnt_q, gnt_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [NUM_CPUS-1:0]   done_q, done_d;
    logic                  shared_q, shared_d;

    logic [IDW-1:0]        pick;
    logic                  found;
    logic [NUM_CPUS-1:0]   self_oh;
    logic [NUM_CPUS-1:0]   others;
    logic                  need_mem;

    // First requester at or after the rotating pointer.
    always_comb begin
        int j;
        pick  = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            j = int'(rr_q) + i;
            if (j >= NUM_CPUS) j = j - NUM_CPUS;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    assign self_oh = NUM_CPUS'(1) << src_q;
    assign others  = ~self_oh;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        src_d       = src_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        ack_d       = ack_q;
        hit_d       = hit_q;
        sup_d       = sup_q;
        gnt_d       = gnt_q;
        bus_valid_d = bus_valid_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        done_d      = '0;
        shared_d    = 1'b0;
        need_mem    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    src_d   = pick;
                    tx_d    = req_tx[pick];
                    addr_d  = req_addr[pick];
                    gnt_d   = NUM_CPUS'(1) << pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                ack_d       = self_oh;
                hit_d       = '0;
                sup_d       = '0;
                bus_valid_d = 1'b1;
                state_d     = S_SNOOP;
            end
            S_SNOOP: begin
                ack_d = ack_q | (snoop_ack & others);
                hit_d = hit_q | (snoop_hit & snoop_ack & others);
                sup_d = sup_q | (snoop_supply & snoop_ack & others);
                need_mem = (tx_q == TX_FLUSH) ||
                           (((tx_q == TX_BUSRD) || (tx_q == TX_BUSRDX)) &&
                            !(|sup_d));
                if (&ack_d) begin
                    bus_valid_d = 1'b0;
                    if (need_mem) begin
                        mem_req_d = 1'b1;
                        mem_we_d  = (tx_q == TX_FLUSH);
                        state_d   = S_MEM;
                    end else begin
                        done_d   = self_oh;
                        shared_d = (tx_q == TX_BUSRD) && (|hit_d);
                        state_d  = S_DONE;
                    end
                end
            end
            S_MEM: begin
                if (mem_resp) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = self_oh;
                    shared_d  = (tx_q == TX_BUSRD) && (|hit_q);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                rr_d    = (src_q == IDW'(NUM_CPUS - 1)) ? '0 : src_q + IDW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            src_q       <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            ack_q       <= '0;
            hit_q       <= '0;
            sup_q       <= '0;
            gnt_q       <= '0;
            bus_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= '0;
            shared_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            src_q       <= src_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            ack_q       <= ack_d;
            hit_q       <= hit_d;
            sup_q       <= sup_d;
            gnt_q       <= gnt_d;
            bus_valid_q <= bus_valid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            shared_q    <= shared_d;
        end
    end

    assign gnt       = gnt_q;
    assign bus_valid = bus_valid_q;
    assign bus_src   = src_q;
    assign bus_tx    = tx_q;
    assign bus_addr  = addr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign done      = done_q;
    assign shared    = shared_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_snoop_txn_sequencer.sv
// Directed bench for snoop_txn_sequencer: grant, snoop, memory, done,
// round-robin order and mid-transaction reset.
module tb_snoop_txn_sequencer;

    localparam int N = 4;
    localparam int XL = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0][1:0] req_tx;
    logic [N-1:0][XL-1:0] req_addr;
    logic [N-1:0]      gnt;
    logic              bus_valid;
    logic [1:0]        bus_src;
    logic [1:0]        bus_tx;
    logic [XL-1:0]     bus_addr;
    logic [N-1:0]      snoop_ack;
    logic [N-1:0]      snoop_hit;
    logic [N-1:0]      snoop_supply;
    logic              mem_req;
    logic              mem_we;
    logic [XL-1:0]     mem_addr;
    logic              mem_resp;
    logic [N-1:0]      done;
    logic              shared;
    logic              busy;

    int total = 0;
    int bad = 0;

    snoop_txn_sequencer #(.NUM_CPUS(N), .XLEN(XL)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_tx(req_tx), .req_addr(req_addr),
        .gnt(gnt), .bus_valid(bus_valid), .bus_src(bus_src),
        .bus_tx(bus_tx), .bus_addr(bus_addr),
        .snoop_ack(snoop_ack), .snoop_hit(snoop_hit),
        .snoop_supply(snoop_supply),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_resp(mem_resp), .done(done), .shared(shared), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        snoop_ack    = '0;
        snoop_hit    = '0;
        snoop_supply = '0;
        mem_resp     = 1'b0;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        req      = '0;
        req_tx   = '0;
        req_addr = '0;
        quiet();
        step();
        step();
        rst = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bv", bus_valid, 0);
        chk("rst_mreq", mem_req, 0);
        chk("rst_done", done, 0);

        // BusUpgr from cpu1, all acks in first SNOOP cycle
        req[1] = 1'b1; req_tx[1] = 2'd2; req_addr[1] = 32'h0000_2000;
        step();
        chk("t1_gnt_g", gnt, 4'b0010);
        chk("t1_bv_g", bus_valid, 0);
        chk("t1_busy", busy, 1);
        req[1] = 1'b0;
        step();
        chk("t1_bv_s", bus_valid, 1);
        chk("t1_src", bus_src, 1);
        chk("t1_tx", bus_tx, 2);
        chk("t1_gnt_s", gnt, 4'b0010);
        snoop_ack = 4'b1101; snoop_hit = 4'b0100;
        step();
        quiet();
        chk("t1_done", done, 4'b0010);
        chk("t1_shared", shared, 0);
        chk("t1_gnt_d", gnt, 4'b0010);
        chk("t1_bv_d", bus_valid, 0);
        chk("t1_mreq", mem_req, 0);
        step();
        chk("t1_idle_gnt", gnt, 0);
        chk("t1_idle_done", done, 0);
        chk("t1_idle_busy", busy, 0);

        // BusRd from cpu0, cpu2 hits first, others late, memory read
        req[0] = 1'b1; req_tx[0] = 2'd0; req_addr[0] = 32'h0000_1040;
        step();
        chk("t2_gnt", gnt, 4'b0001);
        step();
        chk("t2_addr", bus_addr, 32'h0000_1040);
        snoop_ack = 4'b0100; snoop_hit = 4'b0100;
        step();
        quiet();
        mem_resp = 1'b1;
        chk("t2_bv_s2", bus_valid, 1);
        step();
        quiet();
        chk("t2_bv_s3", bus_valid, 1);
        chk("t2_mreq_s3", mem_req, 0);
        snoop_ack = 4'b1010;
        step();
        quiet();
        chk("t2_mreq", mem_req, 1);
        chk("t2_mwe", mem_we, 0);
        chk("t2_maddr", mem_addr, 32'h0000_1040);
        chk("t2_bv_m", bus_valid, 0);
        step();
        step();
        chk("t2_mreq_hold", mem_req, 1);
        step();
        mem_resp = 1'b1;
        step();
        quiet();
        req[0] = 1'b0;
        chk("t2_done", done, 4'b0001);
        chk("t2_shared", shared, 1);
        chk("t2_mreq_off", mem_req, 0);
        step();

        // BusRdX from cpu3, cpu0 supplies: no memory
        req[3] = 1'b1; req_tx[3] = 2'd1; req_addr[3] = 32'h0000_3080;
        step();
        chk("t3_gnt", gnt, 4'b1000);
        step();
        snoop_ack = 4'b0111; snoop_hit = 4'b0001; snoop_supply = 4'b0001;
        step();
        quiet();
        req[3] = 1'b0;
        chk("t3_done", done, 4'b1000);
        chk("t3_shared", shared, 0);
        chk("t3_mreq", mem_req, 0);
        step();

        // Flush from cpu2: write held until response
        req[2] = 1'b1; req_tx[2] = 2'd3; req_addr[2] = 32'h0000_40c0;
        step();
        chk("t4_gnt", gnt, 4'b0100);
        step();
        snoop_ack = 4'b1011; snoop_supply = 4'b0001;
        step();
        quiet();
        chk("t4_mreq", mem_req, 1);
        chk("t4_mwe", mem_we, 1);
        chk("t4_maddr", mem_addr, 32'h0000_40c0);
        step();
        chk("t4_mwe_hold", mem_we, 1);
        mem_resp = 1'b1;
        step();
        quiet();
        req[2] = 1'b0;
        chk("t4_done", done, 4'b0100);
        chk("t4_mreq_off", mem_req, 0);
        step();

        // Reset during MEM aborts with no done pulse
        req[1] = 1'b1; req_tx[1] = 2'd0; req_addr[1] = 32'h0000_5000;
        step();
        chk("t5_gnt", gnt, 4'b0010);
        req[1] = 1'b0;
        step();
        snoop_ack = 4'b1101;
        step();
        quiet();
        chk("t5_mreq", mem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_gnt0", gnt, 0);
        chk("t5_mreq0", mem_req, 0);
        chk("t5_done0", done, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_bv0", bus_valid, 0);
        step();
        chk("t5_done1", done, 0);

        // All requesting: rotation 0,1,2,3,0 after reset
        req = 4'b1111;
        req_tx = '{2'd2, 2'd2, 2'd2, 2'd2};
        snoop_ack = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (gnt == 0 && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("rr_gnt%0d", k), gnt, 32'(1) << (k % 4));
            step();
            step();
            chk($sformatf("rr_done%0d", k), done, 32'(1) << (k % 4));
            step();
        end
        req = '0;
        quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
